sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Single-port scheduler that shares the external ZBT SRAM command slot among three requesters:
  - foreground read requests from the graphics pipeline;
  - SPI image-upload pixel writes;
  - ADC1 foreground-capture pixel writes.
- Issues at most one command per clk to the low-level SRAM PHY.
- Converts (x, y) pixel coordinates to linear addresses.
- Returns read data at a fixed latency so the pipeline's FOREGROUND_FETCH_CYCLE_DELAY holds.

Parameters:
- PRECISION, 11, coordinate width in bits.
- PIXEL_SIZE, 16, pixel data width (RGB565).
- X_RES, 800, frame width in pixels.
- Y_RES, 600, frame height in pixels.
- ADDR_WIDTH, 20, SRAM address width.
- READ_LATENCY, 3, clk cycles from an accepted read request to request_ready; minimum 2.

Ports:
- clk  in  1  system clock (clk_top domain).
- rst_n  in  1  asynchronous active-low reset.
- frozen  in  1  foreground freeze; ADC writes are discarded while high.
- adc_pixel_data  in  38  {x[37:27], y[26:16], pixel[15:0]} from the ADC1 FIFO.
- adc_pixel_ready  in  1  ADC FIFO not empty.
- adc_pixel_read  out  1  FIFO pop, show-ahead; pops the word shown this cycle.
- spi_pixel_ready  in  1  one-cycle strobe that an SPI pixel is valid.
- spi_pixel_x  in  PRECISION  SPI pixel x coordinate.
- spi_pixel_y  in  PRECISION  SPI pixel y coordinate.
- spi_pixel_in  in  PIXEL_SIZE  SPI pixel data.
- request_active  in  1  foreground read request this cycle.
- request_x  in  PRECISION+1  signed foreground read x coordinate.
- request_y  in  PRECISION+1  signed foreground read y coordinate.
- request_ready  out  1  read response valid.
- request_data  out  PIXEL_SIZE  read response pixel.
- cmd_valid  out  1  SRAM command issued this cycle.
- cmd_write  out  1  1 = write, 0 = read.
- cmd_addr  out  ADDR_WIDTH  linear SRAM address.
- cmd_wdata  out  PIXEL_SIZE  write data.
- rd_data  in  PIXEL_SIZE  PHY read data, valid READ_LATENCY-1 cycles after a read command.
- spi_overrun  out  1  sticky; an SPI pixel was lost.
- adc_discard_count  out  16  saturating count of ADC pixels dropped.

Behaviour:
- Reset (async assert, sync deassert): all outputs 0, both counters 0, skid empty, rr_ptr = ADC.
- Address: addr = y*X_RES + x, computed unsigned and truncated to ADDR_WIDTH. A coordinate is in range iff 0 <= x < X_RES and 0 <= y < Y_RES.
- Priority: the foreground read is absolute priority. The pipeline cannot stall, so every request_active cycle produces exactly one response.
- Out-of-range read:
  - No SRAM command is issued; the slot is freed for writes.
  - The response is still delivered at READ_LATENCY with request_data = 0.
- Read tracking: a READ_LATENCY-deep shift register of {valid, in_range} per request.
  - request_ready = valid tap.
  - request_data = in_range ? rd_data : 0.
  - Both outputs are registered.
- SPI skid:
  - A 1-entry skid register captures spi_pixel_ready, so writes are never lost to a single read cycle.
  - If the skid is full, not granted, and a new SPI strobe arrives: the new pixel is dropped and spi_overrun is set (sticky until reset).
  - If the skid is granted in the same cycle as a new strobe, the skid is reloaded and no overrun occurs.
- Write arbitration, in free cycles (no in-range read): round-robin between the SPI skid and ADC.
  - rr_ptr toggles to the other requester after each write grant.
  - If only one requester is pending, it is granted and rr_ptr points to the other.
- ADC handling:
  - ADC is pending only if adc_pixel_ready && !frozen && ADC is in range.
  - When frozen, or when the ADC word is out of range: adc_pixel_read = 1 whenever adc_pixel_ready, and the word is discarded.
  - Each discarded word increments adc_discard_count, saturating at 16'hFFFF.
  - These discard pops use no SRAM slot and may coincide with a read or an SPI write.
- Out-of-range SPI pixels are dropped silently; spi_overrun is not set.
- Grant outputs: cmd_* are registered, 1-cycle issue. adc_pixel_read is combinational from the grant, asserted the same cycle the word is consumed.
- Freeze edge: frozen applies on the next clk evaluation. An ADC write already registered into cmd_* completes.
- rst_n asserted mid-operation: in-flight reads are abandoned; no request_ready is emitted after reset.

Test Plan:
- Reset, then request_active with (x=5, y=2), rd_data=16'hABCD at the PHY -> cmd_addr=1605, cmd_write=0; request_ready=1 and request_data=16'hABCD exactly 3 cycles after the request.
- Read with x=-1 (12'hFFF) -> no cmd_valid; request_ready at +3 with data 0; a pending ADC write is issued in that slot.
- ADC FIFO and SPI both continuously pending, no reads -> cmd alternates ADC/SPI every cycle, starting with ADC; no spi_overrun.
- request_active every cycle for 4 cycles with an SPI strobe in cycles 0 and 2 -> spi_overrun=1; the first SPI pixel is written in cycle 4.
- frozen=1 with 10 ADC words in the FIFO -> 10 adc_pixel_read pulses, no write commands, adc_discard_count=10.
- ADC word (x=799, y=599) -> write to address 479999; ADC word (x=800, y=0) -> discarded and counted.

Source files
------------

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Shares the single ZBT SRAM command slot among three requesters:
// foreground reads from the graphics pipeline, SPI image-upload writes, and
// ADC1 capture writes. At most one command is issued per clk.
//
// Reads have absolute priority because the pipeline cannot stall. Every
// request_active cycle yields exactly one response READ_LATENCY cycles later.
// Out-of-range reads issue no command and return 0.
//
// Writes share the remaining free slots round-robin between the SPI skid
// entry and the ADC FIFO head.
//
// Read timing, with the request presented in cycle 0:
//   cycle 1                : cmd_valid/cmd_addr are visible to the PHY
//   cycle READ_LATENCY-1   : rd_data must be valid
//   cycle READ_LATENCY     : request_ready/request_data are valid
//
// Ports
//   clk, rst_n              : clock, asynchronous active-low reset
//   frozen                  : ADC words are discarded (and counted) while high
//   adc_pixel_data/_ready   : show-ahead ADC FIFO head {x, y, pixel} / not empty
//   adc_pixel_read          : combinational pop of the word shown this cycle
//   spi_pixel_*             : one-cycle SPI pixel strobe with coordinates/data
//   request_active/_x/_y    : foreground read with signed coordinates
//   request_ready/_data     : registered read response
//   cmd_valid/_write/_addr/_wdata : registered SRAM PHY command
//   rd_data                 : PHY read data
//   spi_overrun             : sticky, an in-range SPI pixel was lost
//   adc_discard_count       : saturating count of dropped ADC words
//
// Write round-robin pointer:
//   state  | meaning
//   RR_ADC | ADC wins when both writers are pending
//   RR_SPI | SPI skid wins when both writers are pending
// ---------------------------------------------------------------------------
module sram_arbiter #(
    parameter int PRECISION    = 11,
    parameter int PIXEL_SIZE   = 16,
    parameter int X_RES        = 800,
    parameter int Y_RES        = 600,
    parameter int ADDR_WIDTH   = 20,
    parameter int READ_LATENCY = 3     // minimum 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              frozen,
    input  logic [2*PRECISION+PIXEL_SIZE-1:0] adc_pixel_data,
    input  logic                              adc_pixel_ready,
    output logic                              adc_pixel_read,
    input  logic                              spi_pixel_ready,
    input  logic [PRECISION-1:0]              spi_pixel_x,
    input  logic [PRECISION-1:0]              spi_pixel_y,
    input  logic [PIXEL_SIZE-1:0]             spi_pixel_in,
    input  logic                              request_active,
    input  logic [PRECISION:0]                request_x,
    input  logic [PRECISION:0]                request_y,
    output logic                              request_ready,
    output logic [PIXEL_SIZE-1:0]             request_data,
    output logic                              cmd_valid,
    output logic                              cmd_write,
    output logic [ADDR_WIDTH-1:0]             cmd_addr,
    output logic [PIXEL_SIZE-1:0]             cmd_wdata,
    input  logic [PIXEL_SIZE-1:0]             rd_data,
    output logic                              spi_overrun,
    output logic [15:0]                       adc_discard_count
);

    typedef enum logic {
        RR_ADC = 1'b0,
        RR_SPI = 1'b1
    } rr_e;

    function automatic logic coord_ok(input logic [PRECISION-1:0] x,
                                      input logic [PRECISION-1:0] y);
        return (32'(x) < 32'(X_RES)) && (32'(y) < 32'(Y_RES));
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] lin_addr(input logic [PRECISION-1:0] x,
                                                       input logic [PRECISION-1:0] y);
        logic [31:0] full;
        full = 32'(y) * 32'(X_RES) + 32'(x);
        return full[ADDR_WIDTH-1:0];
    endfunction

    // ---------------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------------
    logic [PRECISION-1:0]  req_x, req_y;
    logic                  req_in, read_go;
    logic [PRECISION-1:0]  adc_x, adc_y;
    logic [PIXEL_SIZE-1:0] adc_pix;
    logic                  adc_in, adc_pend, adc_drop;
    logic                  spi_strobe;
    logic                  grant_adc, grant_spi;

    assign req_x   = request_x[PRECISION-1:0];
    assign req_y   = request_y[PRECISION-1:0];
    // A set sign bit means a negative coordinate, which is always out of range.
    assign req_in  = !request_x[PRECISION] && !request_y[PRECISION] && coord_ok(req_x, req_y);
    assign read_go = request_active && req_in;

    assign adc_x    = adc_pixel_data[2*PRECISION+PIXEL_SIZE-1:PRECISION+PIXEL_SIZE];
    assign adc_y    = adc_pixel_data[PRECISION+PIXEL_SIZE-1:PIXEL_SIZE];
    assign adc_pix  = adc_pixel_data[PIXEL_SIZE-1:0];
    assign adc_in   = coord_ok(adc_x, adc_y);
    assign adc_pend = adc_pixel_ready && !frozen && adc_in;
    // Discards need no SRAM slot, so they pop regardless of reads or SPI grants.
    assign adc_drop = adc_pixel_ready && (frozen || !adc_in);

    // Out-of-range SPI pixels never enter the skid and never flag an overrun.
    assign spi_strobe = spi_pixel_ready && coord_ok(spi_pixel_x, spi_pixel_y);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    rr_e                     rr_q, rr_d;
    logic                    skid_v_q, skid_v_d;
    logic [ADDR_WIDTH-1:0]   skid_addr_q, skid_addr_d;
    logic [PIXEL_SIZE-1:0]   skid_data_q, skid_data_d;
    logic                    cmd_valid_q, cmd_valid_d;
    logic                    cmd_write_q, cmd_write_d;
    logic [ADDR_WIDTH-1:0]   cmd_addr_q, cmd_addr_d;
    logic [PIXEL_SIZE-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic                    overrun_q, overrun_d;
    logic [15:0]             discard_q, discard_d;
    logic [READ_LATENCY-2:0] pipe_v_q;
    logic [READ_LATENCY-2:0] pipe_in_q;
    logic                    rdy_q;
    logic [PIXEL_SIZE-1:0]   rdata_q;

    assign grant_adc = !read_go && adc_pend && (!skid_v_q || rr_q == RR_ADC);
    assign grant_spi = !read_go && skid_v_q && (!adc_pend || rr_q == RR_SPI);

    assign adc_pixel_read = grant_adc || adc_drop;

    always_comb begin
        cmd_valid_d = 1'b0;
        cmd_write_d = 1'b0;
        cmd_addr_d  = '0;
        cmd_wdata_d = '0;
        if (read_go) begin
            cmd_valid_d = 1'b1;
            cmd_addr_d  = lin_addr(req_x, req_y);
        end else if (grant_adc) begin
            cmd_valid_d = 1'b1;
            cmd_write_d = 1'b1;
            cmd_addr_d  = lin_addr(adc_x, adc_y);
            cmd_wdata_d = adc_pix;
        end else if (grant_spi) begin
            cmd_valid_d = 1'b1;
            cmd_write_d = 1'b1;
            cmd_addr_d  = skid_addr_q;
            cmd_wdata_d = skid_data_q;
        end

        rr_d = rr_q;
        if (grant_adc) begin
            rr_d = RR_SPI;
        end else if (grant_spi) begin
            rr_d = RR_ADC;
        end

        // A skid being drained this cycle can accept the new strobe directly.
        skid_v_d    = skid_v_q;
        skid_addr_d = skid_addr_q;
        skid_data_d = skid_data_q;
        overrun_d   = overrun_q;
        if (spi_strobe) begin
            if (!skid_v_q || grant_spi) begin
                skid_v_d    = 1'b1;
                skid_addr_d = lin_addr(spi_pixel_x, spi_pixel_y);
                skid_data_d = spi_pixel_in;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (grant_spi) begin
            skid_v_d = 1'b0;
        end

        discard_d = discard_q;
        if (adc_drop && discard_q != 16'hFFFF) begin
            discard_d = discard_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q        <= RR_ADC;
            skid_v_q    <= 1'b0;
            skid_addr_q <= '0;
            skid_data_q <= '0;
            cmd_valid_q <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            overrun_q   <= 1'b0;
            discard_q   <= '0;
            pipe_v_q    <= '0;
            pipe_in_q   <= '0;
            rdy_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rr_q        <= rr_d;
            skid_v_q    <= skid_v_d;
            skid_addr_q <= skid_addr_d;
            skid_data_q <= skid_data_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            overrun_q   <= overrun_d;
            discard_q   <= discard_d;

            // Response tracker: READ_LATENCY-1 stages, then the output register.
            pipe_v_q[0]  <= request_active;
            pipe_in_q[0] <= read_go;
            for (int i = 1; i < READ_LATENCY - 1; i++) begin
                pipe_v_q[i]  <= pipe_v_q[i-1];
                pipe_in_q[i] <= pipe_in_q[i-1];
            end
            rdy_q   <= pipe_v_q[READ_LATENCY-2];
            rdata_q <= pipe_in_q[READ_LATENCY-2] ? rd_data : '0;
        end
    end

    assign cmd_valid         = cmd_valid_q;
    assign cmd_write         = cmd_write_q;
    assign cmd_addr          = cmd_addr_q;
    assign cmd_wdata         = cmd_wdata_q;
    assign request_ready     = rdy_q;
    assign request_data      = rdata_q;
    assign spi_overrun       = overrun_q;
    assign adc_discard_count = discard_q;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    localparam int XR  = 800;
    localparam int YR  = 600;
    localparam int LAT = 3;

    logic        clk;
    logic        rst_n;
    logic        frozen;
    logic [37:0] adc_pixel_data;
    logic        adc_pixel_ready;
    logic        adc_pixel_read;
    logic        spi_pixel_ready;
    logic [10:0] spi_pixel_x, spi_pixel_y;
    logic [15:0] spi_pixel_in;
    logic        request_active;
    logic [11:0] request_x, request_y;
    logic        request_ready;
    logic [15:0] request_data;
    logic        cmd_valid, cmd_write;
    logic [19:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic [15:0] rd_data;
    logic        spi_overrun;
    logic [15:0] adc_discard_count;

    sram_arbiter #(
        .PRECISION(11), .PIXEL_SIZE(16), .X_RES(XR), .Y_RES(YR),
        .ADDR_WIDTH(20), .READ_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frozen(frozen),
        .adc_pixel_data(adc_pixel_data), .adc_pixel_ready(adc_pixel_ready),
        .adc_pixel_read(adc_pixel_read),
        .spi_pixel_ready(spi_pixel_ready), .spi_pixel_x(spi_pixel_x),
        .spi_pixel_y(spi_pixel_y), .spi_pixel_in(spi_pixel_in),
        .request_active(request_active), .request_x(request_x), .request_y(request_y),
        .request_ready(request_ready), .request_data(request_data),
        .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .rd_data(rd_data),
        .spi_overrun(spi_overrun), .adc_discard_count(adc_discard_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // stimulus for the next cycle
    logic        s_req, s_spi, s_frozen;
    logic [11:0] s_rx, s_ry;
    logic [10:0] s_sx, s_sy;
    logic [15:0] s_sp;
    logic [37:0] fifo[$];

    // PHY model
    logic        phy_force_en;
    logic [15:0] phy_force_val;
    logic [15:0] phy_cur, phy_nxt;

    // reference model state
    typedef struct {
        int          due;
        logic [15:0] data;
    } resp_t;
    resp_t       resp_q[$];
    logic        m_skid_v;
    int          m_skid_addr;
    logic [15:0] m_skid_data;
    logic        m_rr_adc;
    logic        m_overrun;
    int          m_count;
    logic        e_valid, e_write;
    int          e_addr;
    logic [15:0] e_wdata;
    logic        last_pop;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] phy_f(input int addr);
        logic [19:0] a;
        if (phy_force_en) return phy_force_val;
        a = 20'(addr);
        return a[15:0] ^ 16'hC3A5 ^ {12'h000, a[19:16]};
    endfunction

    function automatic logic in_rng(input int x, input int y);
        return x >= 0 && x < XR && y >= 0 && y < YR;
    endfunction

    function automatic logic [37:0] adc_word(input int x, input int y, input logic [15:0] p);
        return {11'(x), 11'(y), p};
    endfunction

    task automatic model_clear();
        resp_q.delete();
        m_skid_v = 0; m_skid_addr = 0; m_skid_data = '0;
        m_rr_adc = 1; m_overrun = 0; m_count = 0;
        e_valid = 0; e_write = 0; e_addr = 0; e_wdata = '0;
        phy_cur = '0; phy_nxt = '0;
    endtask

    // Evaluates this cycle's inputs from the rules: reads first, then a
    // round-robin write choice, then the skid, overrun and discard updates.
    task automatic model_eval();
        int rx, ry, ax, ay, sx, sy, writer;
        logic rd_hit, adc_av, adc_ok, adc_drop, exp_pop;
        logic [15:0] ap;
        rx = $signed(s_rx); ry = $signed(s_ry);
        rd_hit = s_req && in_rng(rx, ry);
        if (s_req) begin
            resp_t r;
            r.due  = cyc + LAT;
            r.data = rd_hit ? phy_f(ry * XR + rx) : 16'h0000;
            resp_q.push_back(r);
        end
        adc_av = fifo.size() != 0;
        ax = 0; ay = 0; ap = '0;
        if (adc_av) begin
            ax = int'(fifo[0][37:27]); ay = int'(fifo[0][26:16]); ap = fifo[0][15:0];
        end
        adc_ok   = adc_av && !s_frozen && in_rng(ax, ay);
        adc_drop = adc_av && !adc_ok;
        writer = 0;
        if (!rd_hit) begin
            if (adc_ok && m_skid_v) writer = m_rr_adc ? 1 : 2;
            else if (adc_ok)        writer = 1;
            else if (m_skid_v)      writer = 2;
        end
        exp_pop = adc_drop || writer == 1;
        chk("adc_pixel_read", adc_pixel_read, exp_pop);
        last_pop = adc_pixel_read;

        e_valid = 0; e_write = 0; e_addr = 0; e_wdata = '0;
        if (rd_hit) begin
            e_valid = 1; e_addr = ry * XR + rx;
        end else if (writer == 1) begin
            e_valid = 1; e_write = 1; e_addr = ay * XR + ax; e_wdata = ap;
        end else if (writer == 2) begin
            e_valid = 1; e_write = 1; e_addr = m_skid_addr; e_wdata = m_skid_data;
        end
        if (writer != 0) m_rr_adc = (writer == 2);

        sx = int'(s_sx); sy = int'(s_sy);
        if (s_spi && in_rng(sx, sy)) begin
            if (!m_skid_v || writer == 2) begin
                m_skid_v = 1; m_skid_addr = sy * XR + sx; m_skid_data = s_sp;
            end else begin
                m_overrun = 1;
            end
        end else if (writer == 2) begin
            m_skid_v = 0;
        end
        if (adc_drop && m_count < 65535) m_count++;
        if (exp_pop) void'(fifo.pop_front());
    endtask

    task automatic check_regs();
        logic exp_rdy;
        chk("cmd_valid", cmd_valid, e_valid);
        if (e_valid) begin
            chk("cmd_write", cmd_write, e_write);
            chk("cmd_addr", cmd_addr, e_addr);
            chk("cmd_wdata", cmd_wdata, e_wdata);
        end
        exp_rdy = resp_q.size() != 0 && resp_q[0].due == cyc;
        chk("request_ready", request_ready, exp_rdy);
        if (exp_rdy) begin
            chk("request_data", request_data, resp_q[0].data);
            void'(resp_q.pop_front());
        end
        chk("spi_overrun", spi_overrun, m_overrun);
        chk("adc_discard_count", adc_discard_count, m_count);
        // PHY returns data one cycle after it sees a read command
        phy_cur = phy_nxt;
        phy_nxt = (cmd_valid && !cmd_write) ? phy_f(int'(cmd_addr)) : 16'($urandom);
    endtask

    task automatic step();
        request_active  = s_req;
        request_x       = s_rx;
        request_y       = s_ry;
        spi_pixel_ready = s_spi;
        spi_pixel_x     = s_sx;
        spi_pixel_y     = s_sy;
        spi_pixel_in    = s_sp;
        frozen          = s_frozen;
        rd_data         = phy_cur;
        adc_pixel_ready = fifo.size() != 0;
        adc_pixel_data  = (fifo.size() != 0) ? fifo[0] : 38'h0;
        #1;
        model_eval();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_regs();
    endtask

    task automatic idle_stim();
        s_req = 0; s_spi = 0; s_frozen = 0;
        s_rx = '0; s_ry = '0; s_sx = '0; s_sy = '0; s_sp = '0;
    endtask

    task automatic do_reset();
        idle_stim();
        fifo.delete();
        request_active = 0; spi_pixel_ready = 0; frozen = 0;
        adc_pixel_ready = 0; adc_pixel_data = '0; rd_data = '0;
        request_x = '0; request_y = '0; spi_pixel_x = '0; spi_pixel_y = '0; spi_pixel_in = '0;
        rst_n = 0;
        #1;
        chk("rst cmd_valid", cmd_valid, 1'b0);
        chk("rst request_ready", request_ready, 1'b0);
        chk("rst request_data", request_data, 16'h0);
        chk("rst spi_overrun", spi_overrun, 1'b0);
        chk("rst adc_discard_count", adc_discard_count, 16'h0);
        chk("rst adc_pixel_read", adc_pixel_read, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_clear();
    endtask

    function automatic logic [11:0] rcoord(input int res);
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 12'hFFF - 12'($urandom_range(0, 15));
        if (r == 1) return 12'($urandom_range(res, 2047));
        return 12'($urandom_range(0, res - 1));
    endfunction

    int pops, writes;
    logic [3:0] nib;

    initial begin
        phy_force_en = 0; phy_force_val = '0;
        model_clear();
        do_reset();

        // read (5,2) -> address 1605, data back exactly 3 cycles later
        phy_force_en = 1; phy_force_val = 16'hABCD;
        s_req = 1; s_rx = 12'd5; s_ry = 12'd2;
        step();
        chk("t1 cmd_valid", cmd_valid, 1'b1);
        chk("t1 cmd_write", cmd_write, 1'b0);
        chk("t1 cmd_addr", cmd_addr, 20'd1605);
        idle_stim();
        step();
        chk("t1 early ready", request_ready, 1'b0);
        step();
        chk("t1 ready", request_ready, 1'b1);
        chk("t1 data", request_data, 16'hABCD);
        phy_force_en = 0;

        // out-of-range read frees the slot for a pending ADC write
        do_reset();
        fifo.push_back(adc_word(10, 10, 16'hBEEF));
        s_req = 1; s_rx = 12'hFFF; s_ry = 12'd0;
        step();
        chk("t2 cmd_valid", cmd_valid, 1'b1);
        chk("t2 cmd_write", cmd_write, 1'b1);
        chk("t2 cmd_addr", cmd_addr, 20'd8010);
        chk("t2 cmd_wdata", cmd_wdata, 16'hBEEF);
        idle_stim();
        step();
        step();
        chk("t2 ready", request_ready, 1'b1);
        chk("t2 data", request_data, 16'h0000);

        // ADC and SPI both pending: strict alternation starting with ADC
        do_reset();
        for (int i = 0; i < 8; i++) fifo.push_back(adc_word(i, 3, 16'hA000 + 16'(i)));
        for (int k = 0; k < 8; k++) begin
            s_spi = (k == 0) || (k % 2 == 1);
            s_sx = 11'(100 + k); s_sy = 11'd7; s_sp = 16'h5000 + 16'(k);
            step();
            nib = cmd_wdata[15:12];
            chk("t3 alt valid", cmd_valid, 1'b1);
            chk("t3 alt source", nib, (k % 2 == 0) ? 4'hA : 4'h5);
        end
        chk("t3 no overrun", spi_overrun, 1'b0);
        idle_stim();

        // four back-to-back reads with SPI strobes in cycles 0 and 2
        do_reset();
        for (int k = 0; k < 5; k++) begin
            s_req = (k < 4); s_rx = 12'd1; s_ry = 12'd1;
            s_spi = (k == 0) || (k == 2);
            s_sx = 11'd20; s_sy = 11'd0; s_sp = (k == 0) ? 16'h5111 : 16'h5222;
            step();
        end
        chk("t4 spi write valid", cmd_valid, 1'b1);
        chk("t4 spi write", cmd_write, 1'b1);
        chk("t4 spi wdata", cmd_wdata, 16'h5111);
        chk("t4 overrun", spi_overrun, 1'b1);
        idle_stim();

        // frozen: every word is popped and counted, nothing written
        do_reset();
        for (int i = 0; i < 10; i++) fifo.push_back(adc_word(i, i, 16'h1000 + 16'(i)));
        pops = 0; writes = 0;
        s_frozen = 1;
        for (int k = 0; k < 12; k++) begin
            step();
            if (last_pop) pops++;
            if (cmd_valid && cmd_write) writes++;
        end
        chk("t5 pops", pops, 10);
        chk("t5 writes", writes, 0);
        chk("t5 discard count", adc_discard_count, 16'd10);
        idle_stim();

        // corner pixel written, x == X_RES discarded
        do_reset();
        fifo.push_back(adc_word(799, 599, 16'h1234));
        fifo.push_back(adc_word(800, 0, 16'h4321));
        step();
        chk("t6 corner valid", cmd_valid, 1'b1);
        chk("t6 corner addr", cmd_addr, 20'd479999);
        step();
        chk("t6 discard no cmd", cmd_valid, 1'b0);
        chk("t6 discard count", adc_discard_count, 16'd1);

        // randomized traffic with a reset in the middle
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            s_req = $urandom_range(0, 99) < 40;
            s_rx  = rcoord(XR);
            s_ry  = rcoord(YR);
            s_spi = $urandom_range(0, 99) < 30;
            s_sx  = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(XR, 2047)) : 11'($urandom_range(0, XR - 1));
            s_sy  = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(YR, 2047)) : 11'($urandom_range(0, YR - 1));
            s_sp  = 16'($urandom);
            if ($urandom_range(0, 99) < 3) s_frozen = !s_frozen;
            if (fifo.size() < 16 && $urandom_range(0, 99) < 35) begin
                int ax, ay;
                ax = ($urandom_range(0, 9) == 0) ? $urandom_range(XR, 2047) : $urandom_range(0, XR - 1);
                ay = ($urandom_range(0, 9) == 0) ? $urandom_range(YR, 2047) : $urandom_range(0, YR - 1);
                fifo.push_back(adc_word(ax, ay, 16'($urandom)));
            end
            step();
        end
        idle_stim();
        for (int i = 0; i < LAT + 2; i++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
